sha_block_feeder: RTL
=====================

// Module: sha_block_feeder
// PURPOSE
// - Front end for sha_math_core; drives its first_state/next_state/initial_state/message_block
//   inputs and consumes status/block_digester.
// - Accepts a message as a 32-bit big-endian word stream and applies SHA-256 padding
//   (0x80, zero fill, 64-bit bit-length).
// - Issues one 512-bit block per core command and returns the final 256-bit digest.
// PARAMETERS
// - INIT_STATE  256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667
//   SHA-256 IV, H0 in [31:0]; driven on core_initial_state.
// PORTS
// clk                 in   1    clock; all state on rising edge
// reset_n             in   1    asynchronous, active-low reset
// in_valid            in   1    in_data word valid
// in_ready            out  1    feeder accepts word this cycle
// in_data             in   32   message word; first byte in [31:24]
// in_last             in   1    final word of message
// in_bytes            in   2    valid bytes in last word: 1..3, 0 = 4; ignored unless in_last
// core_first_state    out  1    1-cycle pulse: first block of message
// core_next_state     out  1    1-cycle pulse: subsequent block
// core_initial_state  out  256  constant INIT_STATE
// core_message_block  out  512  block; word0 in [511:480]; stable from pulse until core_status returns
// core_status         in   1    core idle/ready
// core_digest         in   256  core block_digester
// digest_valid        out  1    1-cycle pulse: digest updated
// digest              out  256  final message digest; held until next digest_valid
// busy                out  1    message in progress (state != IDLE)
// BEHAVIOUR
// - Reset (async, immediate) values:
//   - All outputs 0 except core_initial_state = INIT_STATE.
//   - FSM = IDLE; word counter wcnt = 0; 64-bit length counter = 0; first-block flag = 1.
// - FSM states: IDLE, FILL, PAD, LEN, ISSUE, WAIT, DONE.
// - IDLE/FILL: in_ready = 1.
//   - Accepted word written to slot wcnt; wcnt++; bitlen += 32, or 8*in_bytes on last.
//   - IDLE -> FILL on first accepted word.
//   - wcnt 15 accepted and !in_last -> ISSUE, with ret = FILL.
//   - in_last: mask unused bytes to 0; place 0x80 in the byte after the last valid byte.
//     - If in_bytes = 0, the 0x80 goes to word wcnt+1 (block boundary -> new block).
//     - Then go to PAD.
// - PAD: one word per cycle, zero-filled.
//   - Pad byte lands in word <= 13 (byte offset L mod 64 <= 55): go to LEN.
//   - Otherwise: zero to word 15, ISSUE with ret = PAD, restart at word 0, then LEN.
// - LEN: words 14/15 = bitlen[63:32]/bitlen[31:0]; ISSUE with ret = DONE.
// - ISSUE: entered only when core_status = 1; otherwise wait here.
//   - Pulse core_first_state if first-block flag, else core_next_state; clear flag -> WAIT.
// - WAIT: ignore core_status on the first cycle (core deasserts after the pulse).
//   - Then core_status = 1 -> wcnt = 0, go to ret.
// - DONE:
//   - Cycle 1: digest <= core_digest; digest_valid = 1.
//   - Cycle 2: reset length/flag, go to IDLE.
// - in_ready = 0 in PAD, LEN, ISSUE, WAIT, DONE; words presented then are not consumed.
// - Length counter wraps mod 2^64, with no error.
// - Message must be >= 1 byte (in_last on a word).
// - Reset mid-block or mid-WAIT: feeder aborts to IDLE; core must be reset concurrently.
// TESTING
// 1. "abc": in_data 32'h61626300, in_last, in_bytes 3
//    -> one first_state pulse; block 512'h61626380_0..0_00000018;
//    -> digest BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD.
// 2. 56-byte "abcdbcdecdef...nopq" (14 words)
//    -> first_state, then next_state with block 0..01C0;
//    -> digest 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1.
// 3. 55-byte message (in_bytes 3 on word 13)
//    -> exactly one block; 0x80 at byte 55; word15 = 32'h000001B8.
// 4. 64-byte message (in_bytes 0 on word 15)
//    -> two blocks; second = 80000000_0..0_00000200.
// 5. Hold core_status low 20 cycles before pulse
//    -> no pulse, in_ready = 0, block stable; pulse 1 cycle after status rises.
// 6. reset_n low during WAIT
//    -> all outputs 0 immediately, busy = 0; next "abc" gives TC1 digest.

Source files
------------

// File: rtl/sha_block_feeder_if.sv
// Message word stream into the SHA-256 block feeder.
// The master drives words and the slave (the feeder) answers with in_ready.
interface sha_block_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_bytes;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output in_bytes,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  in_bytes,
        output in_ready
    );
endinterface

// File: rtl/sha_block_feeder.sv
// SHA-256 front end: packs a big-endian word stream into padded 512-bit blocks,
// sequences them through the compression core and returns the final digest.
module sha_block_feeder #(
    parameter logic [255:0] INIT_STATE =
        256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667
) (
    input  logic                clk,
    input  logic                reset_n,
    sha_block_feeder_if.slave   msg,
    output logic                core_first_state,
    output logic                core_next_state,
    output logic [255:0]        core_initial_state,
    output logic [511:0]        core_message_block,
    input  logic                core_status,
    input  logic [255:0]        core_digest,
    output logic                digest_valid,
    output logic [255:0]        digest,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    state_t      ret;
    logic [31:0] blk [16];
    logic [4:0]  wcnt;
    logic [63:0] bitlen;
    logic        first_blk;
    logic        pad_placed;
    logic        wait_skip;
    logic        done_phase;
    logic        armed;
    logic        accept;
    logic [31:0] last_word;
    logic [63:0] len_inc;

    assign core_initial_state = INIT_STATE;
    assign busy               = (state != IDLE);
    // armed keeps in_ready low while reset is held and for the first edge after it
    assign msg.in_ready       = armed && ((state == IDLE) || (state == FILL));
    assign accept             = msg.in_valid && msg.in_ready;
    assign len_inc            = (msg.in_last && (msg.in_bytes != 2'd0)) ?
                                {59'd0, msg.in_bytes, 3'b000} : 64'd32;

    for (genvar gi = 0; gi < 16; gi++) begin : g_blk
        assign core_message_block[511-32*gi -: 32] = blk[gi];
    end

    always_comb begin
        case (msg.in_bytes)
            2'd1:    last_word = {msg.in_data[31:24], 24'h800000};
            2'd2:    last_word = {msg.in_data[31:16], 16'h8000};
            2'd3:    last_word = {msg.in_data[31:8],  8'h80};
            default: last_word = msg.in_data;
        endcase
    end

    // wcnt is the next slot to write; it reaches 16 when the block is full and
    // WAIT rewinds it to 0 once the core has taken the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            ret              <= FILL;
            wcnt             <= '0;
            bitlen           <= '0;
            first_blk        <= 1'b1;
            pad_placed       <= 1'b0;
            wait_skip        <= 1'b0;
            done_phase       <= 1'b0;
            armed            <= 1'b0;
            core_first_state <= 1'b0;
            core_next_state  <= 1'b0;
            digest_valid     <= 1'b0;
            digest           <= '0;
            for (int i = 0; i < 16; i++) blk[i] <= '0;
        end else begin
            armed            <= 1'b1;
            core_first_state <= 1'b0;
            core_next_state  <= 1'b0;
            digest_valid     <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        blk[wcnt[3:0]] <= msg.in_last ? last_word : msg.in_data;
                        wcnt           <= wcnt + 5'd1;
                        bitlen         <= bitlen + len_inc;
                        if (msg.in_last) begin
                            pad_placed <= (msg.in_bytes != 2'd0);
                            state      <= PAD;
                        end else if (wcnt == 5'd15) begin
                            ret   <= FILL;
                            state <= ISSUE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                // A full-word final beat leaves the 0x80 byte to be placed here
                PAD: begin
                    if (wcnt == 5'd16) begin
                        ret   <= PAD;
                        state <= ISSUE;
                    end else if (pad_placed && (wcnt == 5'd14)) begin
                        state <= LEN;
                    end else begin
                        blk[wcnt[3:0]] <= pad_placed ? 32'h0 : 32'h8000_0000;
                        pad_placed     <= 1'b1;
                        wcnt           <= wcnt + 5'd1;
                    end
                end
                LEN: begin
                    blk[14] <= bitlen[63:32];
                    blk[15] <= bitlen[31:0];
                    ret     <= DONE;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (core_status) begin
                        core_first_state <= first_blk;
                        core_next_state  <= !first_blk;
                        first_blk        <= 1'b0;
                        wait_skip        <= 1'b1;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_skip) begin
                        wait_skip <= 1'b0;
                    end else if (core_status) begin
                        wcnt  <= '0;
                        state <= ret;
                    end
                end
                DONE: begin
                    if (!done_phase) begin
                        digest       <= core_digest;
                        digest_valid <= 1'b1;
                        done_phase   <= 1'b1;
                    end else begin
                        done_phase <= 1'b0;
                        bitlen     <= '0;
                        first_blk  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
